// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
//   Watches a multiplexed, active-low 4-digit seven-segment bus.
//   It waits for each scanned digit to settle and decodes it back to a nibble.
//   Once all four digits have been captured, it publishes them as one coherent frame.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   anode_signals  [3:0] digit enables, active-low, bit n = digit n (bit 3 leftmost)
//   display_out    [6:0] segments, active-low, {g,f,e,d,c,b,a}
//   digits         [15:0] decoded frame, digit n in [4n+3:4n]
//   blank_mask     [3:0] digit n was captured with every segment off
//   frame_valid    one-cycle pulse when digits/blank_mask update
//   decode_error   one-cycle pulse on an illegal anode or segment pattern
//   stale          no frame completed within TIMEOUT_CYCLES
//
// Build option
//   SEVEN_SEG_HEX_DIGITS_EN  when defined, A b C d E F decode to 4'hA..4'hF;
//                            otherwise those patterns are illegal.
//
// state    | meaning
// IDLE     | blanking interval or rejected anode, waiting for a one-hot-low anode
// SETTLE   | one digit selected, waiting for SETTLE_CYCLES identical samples
// CAPTURED | digit decoded (or rejected), holding until the bus changes

module seven_seg_scan_decoder #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  anode_signals,
   input  logic [6:0]  display_out,
   output logic [15:0] digits,
   output logic [3:0]  blank_mask,
   output logic        frame_valid,
   output logic        decode_error,
   output logic        stale
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

   state_t        state, state_nxt;
   logic [3:0]    anode_s1, anode_s2;
   logic [6:0]    seg_s1, seg_s2;
   logic          chg;
   logic [SW-1:0] settle_cnt, settle_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic [3:0]    cap_mask;
   logic [15:0]   shadow;
   logic [3:0]    shadow_blank;
   logic [3:0]    an_low;
   logic          an_idle, an_one;
   logic [1:0]    slot;
   logic [5:0]    dec;
   logic          settled, cap, err, publish;

   // {legal, blank, nibble} from an active-high segment pattern (a = bit 0)
   function automatic logic [5:0] seg_decode(input logic [6:0] seg_ah);
      logic [5:0] r;
      r = 6'b0_0_0000;
      case (seg_ah)
         7'h3F: r = 6'b1_0_0000;
         7'h06: r = 6'b1_0_0001;
         7'h5B: r = 6'b1_0_0010;
         7'h4F: r = 6'b1_0_0011;
         7'h66: r = 6'b1_0_0100;
         7'h6D: r = 6'b1_0_0101;
         7'h7D: r = 6'b1_0_0110;
         7'h07: r = 6'b1_0_0111;
         7'h7F: r = 6'b1_0_1000;
         7'h6F: r = 6'b1_0_1001;
         7'h00: r = 6'b1_1_0000;
`ifdef SEVEN_SEG_HEX_DIGITS_EN
         7'h77: r = 6'b1_0_1010;
         7'h7C: r = 6'b1_0_1011;
         7'h39: r = 6'b1_0_1100;
         7'h5E: r = 6'b1_0_1101;
         7'h79: r = 6'b1_0_1110;
         7'h71: r = 6'b1_0_1111;
`else
`endif
         default: r = 6'b0_0_0000;
      endcase
      return r;
   endfunction

   // chg marks the first cycle a new word sits in the second sync stage, so the
   // settle counter reads 0 exactly while the FSM sees that new word.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         anode_s1   <= 4'hF;
         anode_s2   <= 4'hF;
         seg_s1     <= 7'h7F;
         seg_s2     <= 7'h7F;
         chg        <= 1'b0;
         settle_cnt <= '0;
      end else begin
         anode_s1   <= anode_signals;
         anode_s2   <= anode_s1;
         seg_s1     <= display_out;
         seg_s2     <= seg_s1;
         chg        <= ({anode_s1, seg_s1} != {anode_s2, seg_s2});
         settle_cnt <= ({anode_s1, seg_s1} != {anode_s2, seg_s2}) ? '0 : settle_nxt;
      end
   end

   always_comb begin
      settle_nxt = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SW'(1);
      tmo_nxt    = (tmo_cnt == TIMEOUT_MAX) ? tmo_cnt : tmo_cnt + TW'(1);
      an_low     = ~anode_s2;
      an_idle    = (an_low == 4'b0000);
      an_one     = !an_idle && ((an_low & (an_low - 4'd1)) == 4'b0000);
      dec        = seg_decode(~seg_s2);
      // capture on the edge where the counter reaches SETTLE_CYCLES
      settled    = !chg && (settle_nxt == SETTLE_MAX);
      publish    = (cap_mask == 4'hF);
      slot       = 2'd0;
      case (an_low)
         4'b0010: slot = 2'd1;
         4'b0100: slot = 2'd2;
         4'b1000: slot = 2'd3;
         default: slot = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (an_one)                state_nxt = SETTLE;
            else if (!an_idle && chg)  err = 1'b1;
         end
         SETTLE: begin
            if (an_idle) begin
               state_nxt = IDLE;
            end else if (!an_one) begin
               err       = 1'b1;
               state_nxt = IDLE;
            end else if (settled) begin
               cap       = dec[5];
               err       = !dec[5];
               state_nxt = CAPTURED;
            end
         end
         CAPTURED: begin
            if (chg) begin
               if (an_idle) begin
                  state_nxt = IDLE;
               end else if (an_one) begin
                  state_nxt = SETTLE;
               end else begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow       <= '0;
         shadow_blank <= '0;
         cap_mask     <= '0;
         digits       <= '0;
         blank_mask   <= '0;
         frame_valid  <= 1'b0;
         decode_error <= 1'b0;
         tmo_cnt      <= '0;
         stale        <= 1'b1;
      end else begin
         decode_error <= err;
         frame_valid  <= publish;
         if (cap) begin
            shadow[{slot, 2'b00} +: 4] <= dec[3:0];
            shadow_blank[slot]         <= dec[4];
         end
         if (publish) begin
            digits     <= shadow;
            blank_mask <= shadow_blank;
            // a capture landing on the publish cycle starts the next frame
            cap_mask   <= cap ? (4'b0001 << slot) : 4'b0000;
            tmo_cnt    <= '0;
            stale      <= 1'b0;
         end else begin
            if (cap) cap_mask <= cap_mask | (4'b0001 << slot);
            tmo_cnt <= tmo_nxt;
            if (tmo_nxt == TIMEOUT_MAX) stale <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: table of full scans plus
// hand-written glitch, bad-anode, hex, timeout and mid-scan reset sequences.

module tb_seven_seg_scan_decoder;

   localparam int S = 16;
   localparam int T = 400;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  anode_signals = 4'hF;
   logic [6:0]  display_out = 7'h7F;
   logic [15:0] digits;
   logic [3:0]  blank_mask;
   logic        frame_valid;
   logic        decode_error;
   logic        stale;

   seven_seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .anode_signals(anode_signals),
      .display_out(display_out),
      .digits(digits),
      .blank_mask(blank_mask),
      .frame_valid(frame_valid),
      .decode_error(decode_error),
      .stale(stale)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int err_cnt = 0;

   always @(negedge clk) begin
      if (frame_valid)  fv_cnt++;
      if (decode_error) err_cnt++;
   end

   typedef struct {
      logic [27:0] segs;        // active-high {digit3, digit2, digit1, digit0}
      logic [15:0] exp_digits;
      logic [3:0]  exp_blank;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic show(input int n, input logic [6:0] seg_ah, input int cycles);
      logic [3:0] one;
      one = 4'b0001;
      anode_signals = ~(one << n);
      display_out   = ~seg_ah;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic gap(input int cycles);
      anode_signals = 4'hF;
      display_out   = 7'h7F;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic scan(input logic [27:0] segs);
      logic [6:0] s;
      for (int d = 3; d >= 0; d--) begin
         s = segs[d*7 +: 7];
         show(d, s, 40);
         gap(4);
      end
   endtask

   int fv0, er0;

   initial begin
      vecs[0] = '{segs: {7'h06, 7'h5B, 7'h4F, 7'h66}, exp_digits: 16'h1234, exp_blank: 4'b0000};
      vecs[1] = '{segs: {7'h00, 7'h3F, 7'h6D, 7'h6F}, exp_digits: 16'h0059, exp_blank: 4'b1000};
      vecs[2] = '{segs: {7'h6F, 7'h7F, 7'h07, 7'h7D}, exp_digits: 16'h9876, exp_blank: 4'b0000};
      vecs[3] = '{segs: {7'h6D, 7'h7D, 7'h3F, 7'h06}, exp_digits: 16'h5601, exp_blank: 4'b0000};

      repeat (3) @(negedge clk);
      chk("reset digits", 32'(digits), 32'h0);
      chk("reset blank_mask", 32'(blank_mask), 32'h0);
      chk("reset frame_valid", 32'(frame_valid), 32'h0);
      chk("reset decode_error", 32'(decode_error), 32'h0);
      chk("reset stale", 32'(stale), 32'h1);
      reset_n = 1'b1;
      gap(5);

      for (int i = 0; i < 4; i++) begin
         fv0 = fv_cnt;
         er0 = err_cnt;
         scan(vecs[i].segs);
         chk($sformatf("vec%0d frames", i), 32'(fv_cnt - fv0), 32'd1);
         chk($sformatf("vec%0d errors", i), 32'(err_cnt - er0), 32'd0);
         chk($sformatf("vec%0d digits", i), 32'(digits), 32'(vecs[i].exp_digits));
         chk($sformatf("vec%0d blank", i), 32'(blank_mask), 32'(vecs[i].exp_blank));
         if (i == 0) chk("stale after frame", 32'(stale), 32'h0);
      end

      // 3-cycle "8" glitch in the middle of digit1's dwell
      fv0 = fv_cnt;
      er0 = err_cnt;
      show(3, 7'h06, 40); gap(4);
      show(2, 7'h5B, 40); gap(4);
      show(1, 7'h4F, 20); show(1, 7'h7F, 3); show(1, 7'h4F, 17); gap(4);
      show(0, 7'h66, 40); gap(4);
      chk("glitch frames", 32'(fv_cnt - fv0), 32'd1);
      chk("glitch errors", 32'(err_cnt - er0), 32'd0);
      chk("glitch digits", 32'(digits), 32'h1234);

      // two anodes low at once
      fv0 = fv_cnt;
      er0 = err_cnt;
      anode_signals = 4'b0011;
      display_out   = ~7'h06;
      repeat (20) @(negedge clk);
      gap(10);
      chk("multi-anode errors", 32'(err_cnt - er0), 32'd1);
      chk("multi-anode frames", 32'(fv_cnt - fv0), 32'd0);
      chk("multi-anode digits", 32'(digits), 32'h1234);

      // 'A' on digit0
      fv0 = fv_cnt;
      er0 = err_cnt;
      scan({7'h06, 7'h5B, 7'h4F, 7'h77});
`ifdef SEVEN_SEG_HEX_DIGITS_EN
      chk("hex frames", 32'(fv_cnt - fv0), 32'd1);
      chk("hex digits", 32'(digits), 32'h123A);
`else
      chk("hex errors", 32'(err_cnt - er0), 32'd1);
      chk("hex frames", 32'(fv_cnt - fv0), 32'd0);
`endif

      // stop scanning after one frame
      scan({7'h06, 7'h5B, 7'h4F, 7'h66});
      chk("pre-timeout stale", 32'(stale), 32'h0);
      repeat (350) @(negedge clk);
      chk("near-timeout stale", 32'(stale), 32'h0);
      repeat (40) @(negedge clk);
      chk("timeout stale", 32'(stale), 32'h1);
      chk("timeout digits", 32'(digits), 32'h1234);

      // reset in the middle of a scan
      show(3, 7'h6D, 40); gap(4);
      show(2, 7'h7D, 10);
      reset_n = 1'b0;
      #1;
      chk("midreset digits", 32'(digits), 32'h0);
      chk("midreset blank_mask", 32'(blank_mask), 32'h0);
      chk("midreset frame_valid", 32'(frame_valid), 32'h0);
      chk("midreset decode_error", 32'(decode_error), 32'h0);
      chk("midreset stale", 32'(stale), 32'h1);
      @(negedge clk);
      gap(3);
      reset_n = 1'b1;
      gap(5);
      fv0 = fv_cnt;
      scan({7'h6D, 7'h7D, 7'h07, 7'h7F});
      chk("post-reset frames", 32'(fv_cnt - fv0), 32'd1);
      chk("post-reset digits", 32'(digits), 32'h5678);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart to the stopwatch's multiplexed 4-digit seven-segment output.
- Samples `anode_signals` and `display_out`, waits until each scanned digit has settled, and decodes its segment pattern back to a 4-bit value.
- Publishes a coherent 4-digit frame once every anode has been seen.
- Used as a display monitor in benches and as an on-chip loopback checker for display drivers.

Parameters:
- `SETTLE_CYCLES`, 16: consecutive identical synced samples required before a digit is captured (min 2).
- `TIMEOUT_CYCLES`, 1048576: cycles without a completed frame before `stale` asserts.

Ports:
- `clk`  input  1  system clock.
- `reset_n`  input  1  asynchronous active-low reset.
- `anode_signals`  input  4  digit enables, active-low; bit n selects digit n (bit 3 is leftmost).
- `display_out`  input  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- `digits`  output  16  decoded frame; digit n occupies bits [4n+3:4n].
- `blank_mask`  output  4  bit n high when digit n was captured with all segments off.
- `frame_valid`  output  1  one-cycle pulse when `digits`/`blank_mask` update.
- `decode_error`  output  1  one-cycle pulse on an illegal anode or segment pattern.
- `stale`  output  1  level; high when no frame has completed within `TIMEOUT_CYCLES`.

Behaviour:
- Reset (async assert, sync release):
  - `digits`=0, `blank_mask`=0, `frame_valid`=0, `decode_error`=0, `stale`=1.
  - Capture mask cleared, settle counter cleared, FSM in IDLE.
- Input conditioning:
  - `anode_signals` and `display_out` each pass through a 2-flop synchronizer.
  - All logic below operates on the synced values.
- Settle counter:
  - Resets to 0 when the synced {anode, segment} word differs from its previous-cycle value.
  - Otherwise increments, saturating at `SETTLE_CYCLES`.
- FSM:
  - IDLE:
    - Synced anode = 4'b1111 (blanking interval): stay, no error.
    - Exactly one anode bit low: go to SETTLE.
    - More than one anode bit low: pulse `decode_error`, stay.
  - SETTLE:
    - Any input change: counter restarts, stay in SETTLE.
    - Anode returns to 4'b1111: go to IDLE.
    - Counter reaches `SETTLE_CYCLES`: decode segments.
      - Legal pattern: write nibble and blank bit into shadow slot n, set capture-mask bit n, go to CAPTURED.
      - Illegal pattern: pulse `decode_error`, no capture, go to CAPTURED.
  - CAPTURED:
    - Hold, with no further capture, until the synced word changes.
    - Then go to IDLE (anode 1111) or SETTLE (new one-hot-low anode).
    - Multi-low anode: error pulse, go to IDLE.
- Decode table (active-high equivalent, a=bit0):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 = blank: nibble 0, blank bit set.
  - Anything else is illegal.
- Recapture: a digit recaptured before frame completion overwrites its shadow slot (last value wins).
- Frame completion:
  - Condition: capture mask becomes 4'b1111.
  - Next cycle: shadow copied to `digits`/`blank_mask`, `frame_valid` pulses, mask cleared, timeout counter cleared, `stale` deasserts.
  - Latency from final input change to `frame_valid`: 2 (sync) + `SETTLE_CYCLES` + 1 cycles.
- Timeout counter:
  - Increments every cycle, saturating.
  - On reaching `TIMEOUT_CYCLES`, `stale`=1 until the next `frame_valid`.
  - `digits` hold their last value.
- Counter widths: `$clog2(param+1)`.
- Simultaneity: error pulse and capture never coincide; frame completion and a new anode change in the same cycle are both honoured.
- Reset mid-frame: partial shadow data is discarded.

Optional Feature:
- Macro: `SEVEN_SEG_HEX_DIGITS_EN`.
- Defined: A=77, b=7C, C=39, d=5E, E=79, F=71 decode to nibbles A-F.
- Undefined: those patterns are illegal and pulse `decode_error`.

Test Plan:
- Scan "1234" (digit3='1' … digit0='4'), 40-cycle dwell, 4-cycle 1111 gaps between digits -> one `frame_valid` per full scan; `digits`=16'h1234, `blank_mask`=0, `stale` drops to 0.
- Same scan with a 3-cycle glitch of segment 7F mid-dwell on digit1 -> `digits` still 16'h1234, no `decode_error`.
- Anode 4'b0011 held for 20 cycles -> exactly one `decode_error` pulse; no capture; no `frame_valid`.
- Segments 0x77 (active-high) on digit0 -> macro off: `decode_error`, no frame; macro on: `digits`[3:0]=4'hA.
- Leading digit blank (segments all off), others "059" -> `digits`=16'h0059, `blank_mask`=4'b1000.
- Stop scanning after one frame, wait `TIMEOUT_CYCLES` -> `stale`=1, `digits` unchanged; assert `reset_n` low mid-scan -> all outputs at reset values immediately.
